// File: rtl/inv_sub_bytes_seq.sv
// Time-multiplexed AES InvSubBytes sequencer.
// NUM_ROMS external combinational inverse S-box ROMs are shared across the
// 16 state bytes, so a state takes 16/NUM_ROMS RUN cycles to transform.
module inv_sub_bytes_seq #(
  parameter int unsigned NUM_ROMS = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    abort_i,
  input  logic [127:0]            state_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [8*NUM_ROMS-1:0]   rom_addr_o,
  input  logic [8*NUM_ROMS-1:0]   rom_data_i,
  output logic [127:0]            state_o,
  output logic                    v_o,
  input  logic                    ready_i,
  output logic                    busy_o
);

  localparam int unsigned NUM_BYTES = 16;
  localparam int unsigned ITERS     = NUM_BYTES / NUM_ROMS;
  localparam int unsigned CNT_W     = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t                     fsm_q, fsm_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  // Element [15-k] holds byte k, so element 15 is the MSB byte.
  logic [NUM_BYTES-1:0][7:0] cap_q, cap_d;
  logic [NUM_BYTES-1:0][7:0] res_q, res_d;
  logic [NUM_ROMS-1:0][7:0]  addr_d;
  logic [NUM_ROMS-1:0][7:0]  rom_lane;

  assign rom_lane = rom_data_i;
  assign state_o  = res_q;

  // Next-state, counter and capture logic; abort overrides everything.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    cap_d = cap_q;
    if (abort_i) begin
      fsm_d = IDLE;
      cnt_d = '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (v_i) begin
            cap_d = state_i;
            cnt_d = '0;
            fsm_d = RUN;
          end
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            fsm_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            fsm_d = IDLE;
          end
        end
        default: begin
          fsm_d = IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  // Result byte k is written from lane k%NUM_ROMS in RUN slot k/NUM_ROMS.
  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_res
    localparam int unsigned LANE = k % NUM_ROMS;
    localparam int unsigned SLOT = k / NUM_ROMS;
    assign res_d[NUM_BYTES-1-k] = (fsm_q == RUN && cnt_q == CNT_W'(SLOT))
                                  ? rom_lane[LANE] : res_q[NUM_BYTES-1-k];
  end

  // Next ROM address per lane: byte (cnt*NUM_ROMS + j) of the captured state.
  for (genvar j = 0; j < NUM_ROMS; j++) begin : g_addr
    logic [3:0] pos;
    assign pos       = 4'(NUM_BYTES - 1 - j) - 4'(4'(NUM_ROMS) * 4'(cnt_d));
    assign addr_d[j] = (fsm_d == RUN) ? cap_d[pos] : 8'h00;
  end

  // FSM state register with registered status outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fsm_q   <= IDLE;
      ready_o <= 1'b1;
      v_o     <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      ready_o <= (fsm_d == IDLE);
      v_o     <= (fsm_d == DONE);
      busy_o  <= (fsm_d == RUN);
    end
  end

  // Datapath registers: counter, captured state, result and ROM addresses.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q      <= '0;
      cap_q      <= '0;
      res_q      <= '0;
      rom_addr_o <= '0;
    end else begin
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      res_q      <= res_d;
      rom_addr_o <= addr_d;
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboard bench for inv_sub_bytes_seq with NUM_ROMS = 1, 4 and 16 side by side.
module tb_inv_sub_bytes_seq;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  logic         clk;
  logic         reset_n;
  logic         abort_i;
  logic         ready_i;
  logic [127:0] state_i;
  logic         v_i_w   [3];
  logic         ready_w [3];
  logic         v_w     [3];
  logic         busy_w  [3];
  logic [127:0] st_w    [3];
  logic [127:0] addr_w  [3];

  logic [7:0]        ra1, rd1;
  logic [3:0][7:0]   ra4, rd4;
  logic [15:0][7:0]  ra16, rd16;

  logic [127:0] cap_ref;
  logic [127:0] q0[$], q1[$], q2[$];
  int           checks;
  int           failures;
  bit           tb_done;
  bit           mon_finished;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.NUM_ROMS(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .abort_i(abort_i), .state_i(state_i),
    .v_i(v_i_w[0]), .ready_o(ready_w[0]), .rom_addr_o(ra1), .rom_data_i(rd1),
    .state_o(st_w[0]), .v_o(v_w[0]), .ready_i(ready_i), .busy_o(busy_w[0]));

  inv_sub_bytes_seq #(.NUM_ROMS(4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .abort_i(abort_i), .state_i(state_i),
    .v_i(v_i_w[1]), .ready_o(ready_w[1]), .rom_addr_o(ra4), .rom_data_i(rd4),
    .state_o(st_w[1]), .v_o(v_w[1]), .ready_i(ready_i), .busy_o(busy_w[1]));

  inv_sub_bytes_seq #(.NUM_ROMS(16)) dut16 (
    .clk_i(clk), .reset_n_i(reset_n), .abort_i(abort_i), .state_i(state_i),
    .v_i(v_i_w[2]), .ready_o(ready_w[2]), .rom_addr_o(ra16), .rom_data_i(rd16),
    .state_o(st_w[2]), .v_o(v_w[2]), .ready_i(ready_i), .busy_o(busy_w[2]));

  // Combinational ROM models.
  assign rd1 = INV_SBOX[ra1];
  for (genvar j = 0; j < 4; j++) begin : g_rom4
    assign rd4[j] = INV_SBOX[ra4[j]];
  end
  for (genvar j = 0; j < 16; j++) begin : g_rom16
    assign rd16[j] = INV_SBOX[ra16[j]];
  end

  assign addr_w[0] = 128'(ra1);
  assign addr_w[1] = 128'(ra4);
  assign addr_w[2] = ra16;

  function automatic int lanes(input int ch);
    return (ch == 0) ? 1 : (ch == 1) ? 4 : 16;
  endfunction

  function automatic int lat_exp(input int ch);
    return (ch == 0) ? 17 : (ch == 1) ? 5 : 2;
  endfunction

  function automatic logic [127:0] flags(input int ch);
    return 128'({ready_w[ch], v_w[ch], busy_w[ch]});
  endfunction

  function automatic int qsize(input int ch);
    return (ch == 0) ? q0.size() : (ch == 1) ? q1.size() : q2.size();
  endfunction

  task automatic qpush(input int ch, input logic [127:0] v);
    if (ch == 0) q0.push_back(v);
    else if (ch == 1) q1.push_back(v);
    else q2.push_back(v);
  endtask

  task automatic qpop(input int ch, output logic [127:0] v);
    if (ch == 0) v = q0.pop_front();
    else if (ch == 1) v = q1.pop_front();
    else v = q2.pop_front();
  endtask

  task automatic chk(input string name, input int ch, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h expected=%h", name, ch, act, exp);
    end
  endtask

  // Monitor: protocol invariants, ROM address sequence, latency and scoreboard.
  initial begin : monitor
    int           cyc;
    bit           acc_next;
    bit           prev_v [3];
    logic [127:0] prev_st [3];
    bit           prev_rdy_i, prev_abort, prev_rst;
    logic [127:0] e;
    int           k;
    cyc = 0;
    acc_next = 1'b0;
    prev_rdy_i = 1'b0;
    prev_abort = 1'b0;
    prev_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      prev_v[c] = 1'b0;
      prev_st[c] = '0;
    end
    forever begin
      @(negedge clk);
      cyc = acc_next ? 0 : cyc + 1;
      for (int c = 0; c < 3; c++) begin
        if (!reset_n) begin
          chk("reset_flags", c, flags(c), 128'(3'b100));
          chk("reset_rom_addr", c, addr_w[c], '0);
          chk("reset_state_o", c, st_w[c], '0);
        end else begin
          if (busy_w[c]) begin
            chk("run_flags", c, flags(c), 128'(3'b001));
            for (int j = 0; j < lanes(c); j++) begin
              k = cyc * lanes(c) + j;
              if (k < 16) chk("rom_addr", c, 128'(addr_w[c][8*j +: 8]), 128'(cap_ref[127-8*k -: 8]));
              else chk("rom_addr_range", c, 128'(k), 128'(15));
            end
          end else begin
            chk("rom_addr_idle", c, addr_w[c], '0);
          end
          if (prev_rst && prev_abort) begin
            chk("abort_idle", c, flags(c), 128'(3'b100));
          end else if (prev_rst && prev_v[c] && !prev_rdy_i) begin
            chk("hold_v_o", c, 128'(v_w[c]), 128'(1'b1));
            chk("hold_state_o", c, st_w[c], prev_st[c]);
          end else if (prev_rst && prev_v[c] && prev_rdy_i) begin
            chk("release_flags", c, flags(c), 128'(3'b100));
          end
          if (v_w[c] && !prev_v[c]) begin
            if (qsize(c) == 0) chk("unexpected_v_o", c, 128'(1'b1), 128'(1'b0));
            else chk("latency", c, 128'(cyc + 1), 128'(lat_exp(c)));
            chk("done_flags", c, flags(c), 128'(3'b010));
          end
          if (v_w[c] && ready_i) begin
            if (qsize(c) == 0) begin
              chk("unexpected_output", c, 128'(1'b1), 128'(1'b0));
            end else begin
              qpop(c, e);
              chk("state_o", c, st_w[c], e);
            end
          end
        end
      end
      for (int c = 0; c < 3; c++) begin
        prev_v[c] = v_w[c];
        prev_st[c] = st_w[c];
      end
      prev_rdy_i = ready_i;
      prev_abort = abort_i;
      prev_rst = reset_n;
      acc_next = reset_n && v_i_w[0] && ready_w[0] && !abort_i;
      if (tb_done && !mon_finished) begin
        for (int c = 0; c < 3; c++) chk("queue_drained", c, 128'(qsize(c)), '0);
        mon_finished = 1'b1;
      end
    end
  end

  function automatic bit all_idle();
    return ready_w[0] && ready_w[1] && ready_w[2] && !v_w[0] && !v_w[1] && !v_w[2];
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 60 && !all_idle(); i++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_idle", 0, 128'(all_idle()), 128'(1'b1));
  endtask

  task automatic send(input logic [127:0] s, input logic [127:0] e,
                      input logic [2:0] vmask, input logic [2:0] pmask);
    wait_idle();
    for (int c = 0; c < 3; c++) if (pmask[c]) qpush(c, e);
    cap_ref = s;
    state_i = s;
    for (int c = 0; c < 3; c++) v_i_w[c] = vmask[c];
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) v_i_w[c] = 1'b0;
  endtask

  localparam logic [127:0] V0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] E0  = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] BPV = {4{32'h637cff52}};
  localparam logic [127:0] BPE = {4{32'h00017d48}};

  // Driver: directed scenarios.
  initial begin : driver
    checks = 0;
    failures = 0;
    tb_done = 1'b0;
    mon_finished = 1'b0;
    reset_n = 1'b0;
    abort_i = 1'b0;
    ready_i = 1'b1;
    state_i = '0;
    cap_ref = '0;
    for (int c = 0; c < 3; c++) v_i_w[c] = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    send(V0, E0, 3'b111, 3'b111);
    send({16{8'h63}}, {16{8'h00}}, 3'b111, 3'b111);
    send({16{8'hff}}, {16{8'h7d}}, 3'b111, 3'b111);
    wait_idle();

    // Backpressure in DONE with a competing v_i that must be ignored.
    ready_i = 1'b0;
    send(BPV, BPE, 3'b111, 3'b111);
    for (int i = 0; i < 40 && !v_w[0]; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_v_o", 0, 128'(v_w[0]), 128'(1'b1));
    state_i = '0;
    for (int c = 0; c < 3; c++) v_i_w[c] = 1'b1;
    repeat (10) @(posedge clk);
    #1 ready_i = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) v_i_w[c] = 1'b0;
    wait_idle();

    // Abort in RUN cycle 5; idle blocks see v_i together with abort.
    send(BPV, '0, 3'b001, 3'b000);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    abort_i = 1'b1;
    state_i = {16{8'hff}};
    v_i_w[1] = 1'b1;
    v_i_w[2] = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    for (int c = 0; c < 3; c++) v_i_w[c] = 1'b0;
    wait_idle();
    send({16{8'h63}}, {16{8'h00}}, 3'b111, 3'b111);
    wait_idle();

    // Asynchronous reset between edges in RUN cycle 3.
    send(V0, E0, 3'b111, 3'b100);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send({16{8'h7c}}, {16{8'h01}}, 3'b111, 3'b111);
    wait_idle();

    tb_done = 1'b1;
    for (int i = 0; i < 5 && !mon_finished; i++) @(posedge clk);
    chk("monitor_finished", 0, 128'(mon_finished), 128'(1'b1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
